// File: rtl/mc6502_interrupt_logic.sv
// 6502 interrupt sequencer: reset vector fetch, NMI/BRK/IRQ stacking and vectoring.
// Ports: clk, rst_x (sync, active-high), i_irq_x/i_nmi_x requests,
//   mc2il_* memory/decoder inputs, il2mc_* memory strobes,
//   rf2il_* register file state, il2rf_* PC loads and push handshake.
module mc6502_interrupt_logic (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        i_irq_x,
    input  logic        i_nmi_x,
    input  logic [7:0]  mc2il_data,
    input  logic        mc2il_brk,
    output logic [15:0] il2mc_addr,
    output logic        il2mc_read,
    input  logic [7:0]  rf2il_s,
    input  logic [7:0]  rf2il_psr,
    input  logic [15:0] rf2il_pc,
    output logic [7:0]  il2rf_data,
    output logic        il2rf_set_pcl,
    output logic        il2rf_set_pch,
    output logic        il2rf_pushed
);

    typedef enum logic [2:0] {
        RST_L,
        RST_H,
        IDLE,
        PUSH_H,
        PUSH_L,
        PUSH_P,
        VEC_L,
        VEC_H
    } state_t;

    state_t      state_q, state_d;
    logic        nmi_sync_q, nmi_sync_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        irq_sync_q, irq_sync_d;
    logic        nmi_pending_q, nmi_pending_d;
    logic        brk_q, brk_d;
    logic [15:0] vec_base_q, vec_base_d;

    logic        nmi_edge;
    logic        nmi_req;
    logic        irq_req;
    logic        take_nmi;

    // B and unused bits of the live PSR are replaced on push
    logic        unused_psr;
    assign unused_psr = ^rf2il_psr[5:4];

    assign nmi_edge = nmi_prev_q & ~nmi_sync_q;
    // A fresh edge counts in the same cycle so NMI wins over a
    // simultaneous IRQ that is already visible through its sync flop.
    assign nmi_req  = nmi_pending_q | nmi_edge;
    assign irq_req  = ~irq_sync_q & ~rf2il_psr[2];

    always_comb begin
        state_d    = state_q;
        brk_d      = brk_q;
        vec_base_d = vec_base_q;
        take_nmi   = 1'b0;
        nmi_sync_d = i_nmi_x;
        nmi_prev_d = nmi_sync_q;
        irq_sync_d = i_irq_x;
        unique case (state_q)
            RST_L:  state_d = RST_H;
            RST_H:  state_d = IDLE;
            IDLE: begin
                if (nmi_req) begin
                    take_nmi   = 1'b1;
                    vec_base_d = 16'hfffa;
                    brk_d      = 1'b0;
                    state_d    = PUSH_H;
                end else if (mc2il_brk) begin
                    vec_base_d = 16'hfffe;
                    brk_d      = 1'b1;
                    state_d    = PUSH_H;
                end else if (irq_req) begin
                    vec_base_d = 16'hfffe;
                    brk_d      = 1'b0;
                    state_d    = PUSH_H;
                end
            end
            PUSH_H: state_d = PUSH_L;
            PUSH_L: state_d = PUSH_P;
            PUSH_P: state_d = VEC_L;
            VEC_L:  state_d = VEC_H;
            VEC_H:  state_d = IDLE;
            default: state_d = RST_L;
        endcase
        nmi_pending_d = nmi_req & ~take_nmi;
    end

    always_ff @(posedge clk) begin
        if (rst_x) begin
            state_q       <= RST_L;
            nmi_sync_q    <= 1'b1;
            nmi_prev_q    <= 1'b1;
            irq_sync_q    <= 1'b1;
            nmi_pending_q <= 1'b0;
            brk_q         <= 1'b0;
            vec_base_q    <= 16'hfffe;
        end else begin
            state_q       <= state_d;
            nmi_sync_q    <= nmi_sync_d;
            nmi_prev_q    <= nmi_prev_d;
            irq_sync_q    <= irq_sync_d;
            nmi_pending_q <= nmi_pending_d;
            brk_q         <= brk_d;
            vec_base_q    <= vec_base_d;
        end
    end

    // Outputs are quiet during reset so an aborted sequence cannot
    // leak a push or PC load in the cycle reset is raised.
    always_comb begin
        il2mc_addr    = 16'h0000;
        il2mc_read    = 1'b0;
        il2rf_data    = 8'h00;
        il2rf_set_pcl = 1'b0;
        il2rf_set_pch = 1'b0;
        il2rf_pushed  = 1'b0;
        if (!rst_x) begin
            unique case (state_q)
                RST_L: begin
                    il2mc_addr    = 16'hfffc;
                    il2mc_read    = 1'b1;
                    il2rf_set_pcl = 1'b1;
                    il2rf_data    = mc2il_data;
                end
                RST_H: begin
                    il2mc_addr    = 16'hfffd;
                    il2mc_read    = 1'b1;
                    il2rf_set_pch = 1'b1;
                    il2rf_data    = mc2il_data;
                end
                PUSH_H: begin
                    il2mc_addr   = {8'h01, rf2il_s};
                    il2rf_pushed = 1'b1;
                    il2rf_data   = rf2il_pc[15:8];
                end
                PUSH_L: begin
                    il2mc_addr   = {8'h01, rf2il_s};
                    il2rf_pushed = 1'b1;
                    il2rf_data   = rf2il_pc[7:0];
                end
                PUSH_P: begin
                    il2mc_addr   = {8'h01, rf2il_s};
                    il2rf_pushed = 1'b1;
                    il2rf_data   = {rf2il_psr[7:6], 1'b1, brk_q,
                                    rf2il_psr[3:0]};
                end
                VEC_L: begin
                    il2mc_addr    = vec_base_q;
                    il2mc_read    = 1'b1;
                    il2rf_set_pcl = 1'b1;
                    il2rf_data    = mc2il_data;
                end
                VEC_H: begin
                    il2mc_addr    = vec_base_q + 16'd1;
                    il2mc_read    = 1'b1;
                    il2rf_set_pch = 1'b1;
                    il2rf_data    = mc2il_data;
                end
                default: begin
                    il2mc_addr = 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc6502_interrupt_logic.sv
// Scoreboard bench for mc6502_interrupt_logic: directed stimulus queues
// expected bus events; a negedge monitor pops and compares them.
module tb_mc6502_interrupt_logic;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        i_irq_x;
    logic        i_nmi_x;
    logic [7:0]  mc2il_data;
    logic        mc2il_brk;
    logic [15:0] il2mc_addr;
    logic        il2mc_read;
    logic [7:0]  rf2il_s;
    logic [7:0]  rf2il_psr;
    logic [15:0] rf2il_pc;
    logic [7:0]  il2rf_data;
    logic        il2rf_set_pcl;
    logic        il2rf_set_pch;
    logic        il2rf_pushed;

    mc6502_interrupt_logic dut (
        .clk           (clk),
        .rst_x         (rst_x),
        .i_irq_x       (i_irq_x),
        .i_nmi_x       (i_nmi_x),
        .mc2il_data    (mc2il_data),
        .mc2il_brk     (mc2il_brk),
        .il2mc_addr    (il2mc_addr),
        .il2mc_read    (il2mc_read),
        .rf2il_s       (rf2il_s),
        .rf2il_psr     (rf2il_psr),
        .rf2il_pc      (rf2il_pc),
        .il2rf_data    (il2rf_data),
        .il2rf_set_pcl (il2rf_set_pcl),
        .il2rf_set_pch (il2rf_set_pch),
        .il2rf_pushed  (il2rf_pushed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic [7:0]  data;
        logic        pcl;
        logic        pch;
        logic        psh;
        int          gap;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [27:0] obs;
    logic [27:0] expv;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_evt = 0;
    int          n_evt = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle with a strobe must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            obs = {il2mc_addr, il2mc_read, il2rf_data,
                   il2rf_set_pcl, il2rf_set_pch, il2rf_pushed};
            if (rst_x) begin
                chk(obs == 28'h0, "rst_quiet", {4'h0, obs}, 32'h0);
                last_evt = cyc;
            end else if (il2mc_read | il2rf_pushed |
                         il2rf_set_pcl | il2rf_set_pch) begin
                n_evt++;
                chk(q.size() > 0, "unexpected", {4'h0, obs}, 32'h0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    expv = {e.addr, e.rd, e.data, e.pcl, e.pch, e.psh};
                    chk(obs == expv, "event", {4'h0, obs}, {4'h0, expv});
                    if (e.gap != 0)
                        chk(cyc - last_evt == e.gap, "gap",
                            cyc - last_evt, e.gap);
                end
                last_evt = cyc;
            end else begin
                chk(obs == 28'h0, "idle_quiet", {4'h0, obs}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [15:0] a, input logic rd,
                      input logic [7:0] d, input logic pcl,
                      input logic pch, input logic psh, input int gap);
        exp_t x;
        x.addr = a;
        x.rd   = rd;
        x.data = d;
        x.pcl  = pcl;
        x.pch  = pch;
        x.psh  = psh;
        x.gap  = gap;
        q.push_back(x);
    endtask

    task automatic seq(input logic [15:0] sa, input logic [7:0] h,
                       input logic [7:0] l, input logic [7:0] p,
                       input logic [15:0] va, input logic [15:0] vb,
                       input logic [7:0] vd, input int gap0);
        ev(sa, 1'b0, h, 1'b0, 1'b0, 1'b1, gap0);
        ev(sa, 1'b0, l, 1'b0, 1'b0, 1'b1, 1);
        ev(sa, 1'b0, p, 1'b0, 1'b0, 1'b1, 1);
        ev(va, 1'b1, vd, 1'b1, 1'b0, 1'b0, 1);
        ev(vb, 1'b1, vd, 1'b0, 1'b1, 1'b0, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        chk(q.size() == 0, name, q.size(), 0);
        q.delete();
        tick(3);
    endtask

    initial begin
        int n0;
        rst_x      = 1'b1;
        i_irq_x    = 1'b1;
        i_nmi_x    = 1'b1;
        mc2il_brk  = 1'b0;
        mc2il_data = 8'h89;
        rf2il_s    = 8'h00;
        rf2il_psr  = 8'h00;
        rf2il_pc   = 16'h0000;
        tick(3);

        // reset vector fetch right after release
        ev(16'hfffc, 1'b1, 8'h89, 1'b1, 1'b0, 1'b0, 1);
        ev(16'hfffd, 1'b1, 8'h89, 1'b0, 1'b1, 1'b0, 1);
        rst_x = 1'b0;
        drain("reset_vec");

        // single-cycle IRQ pulse, S wraps to 0x0100
        mc2il_data = 8'h5a;
        seq(16'h0100, 8'h00, 8'h00, 8'h20,
            16'hfffe, 16'hffff, 8'h5a, 0);
        i_irq_x = 1'b0;
        tick(1);
        i_irq_x = 1'b1;
        drain("irq_pulse");

        // NMI pulse ignores I
        rf2il_pc  = 16'h1234;
        rf2il_s   = 8'hfd;
        rf2il_psr = 8'h04;
        seq(16'h01fd, 8'h12, 8'h34, 8'h24,
            16'hfffa, 16'hfffb, 8'h5a, 0);
        i_nmi_x = 1'b0;
        tick(1);
        i_nmi_x = 1'b1;
        drain("nmi_pulse");

        // IRQ masked by I
        n0 = n_evt;
        i_irq_x = 1'b0;
        tick(20);
        chk(n_evt == n0, "irq_masked", n_evt, n0);
        i_irq_x = 1'b1;
        tick(2);

        // NMI and IRQ together: NMI first, IRQ right after
        rf2il_psr = 8'h00;
        rf2il_s   = 8'h80;
        rf2il_pc  = 16'habcd;
        seq(16'h0180, 8'hab, 8'hcd, 8'h20,
            16'hfffa, 16'hfffb, 8'h5a, 0);
        seq(16'h0180, 8'hab, 8'hcd, 8'h20,
            16'hfffe, 16'hffff, 8'h5a, 2);
        i_nmi_x = 1'b0;
        i_irq_x = 1'b0;
        tick(1);
        i_nmi_x = 1'b1;
        tick(7);
        i_irq_x = 1'b1;
        drain("nmi_irq");

        // BRK sets B; NMI arriving mid-sequence follows at once
        rf2il_s  = 8'h10;
        rf2il_pc = 16'h0400;
        seq(16'h0110, 8'h04, 8'h00, 8'h30,
            16'hfffe, 16'hffff, 8'h5a, 0);
        seq(16'h0110, 8'h04, 8'h00, 8'h20,
            16'hfffa, 16'hfffb, 8'h5a, 2);
        mc2il_brk = 1'b1;
        tick(1);
        mc2il_brk = 1'b0;
        tick(1);
        i_nmi_x = 1'b0;
        tick(1);
        i_nmi_x = 1'b1;
        drain("brk_nmi");

        // reset during PUSH_L aborts the BRK sequence
        mc2il_data = 8'hc3;
        ev(16'h0110, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 0);
        mc2il_brk = 1'b1;
        tick(1);
        mc2il_brk = 1'b0;
        tick(1);
        rst_x = 1'b1;
        ev(16'hfffc, 1'b1, 8'hc3, 1'b1, 1'b0, 1'b0, 1);
        ev(16'hfffd, 1'b1, 8'hc3, 1'b0, 1'b1, 1'b0, 1);
        tick(2);
        rst_x = 1'b0;
        drain("brk_abort");
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
